aquisicao_pressao: RTL and testbench

Pressure-sensor acquisition stage that sits directly upstream of `sistemaDeVentilacao`. It scans the seven ventilation pressure channels through a shared converter using a request/valid handshake, and debounces each reading with a per-channel persistence filter. It presents one registered 4-bit signed value per channel, with the same names the ventilation controller consumes, and flags a channel as faulty when its converter does not answer in time.

---
 rtl/aquisicao_pressao.sv | 144 ++++++++++++++
 tb/tb_aquisicao_pressao.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/aquisicao_pressao.sv
// Scans seven pressure channels through a shared converter and applies a persistence filter to each channel.
// Latency: 2 cycles per channel when the converter answers at once; an output updates on the edge that ends ATUALIZA.
// Backpressure: the converter must answer within TIMEOUT cycles, otherwise the channel is flagged and skipped.
module aquisicao_pressao #(
    parameter int PERSIST = 3,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       habilita,
    output logic       reqAmostra,
    output logic [2:0] canalSel,
    input  logic [3:0] dadoADC,
    input  logic       validoADC,
    output logic [3:0] sensPresSC,
    output logic [3:0] sensPresS1,
    output logic [3:0] sensPresS2,
    output logic [3:0] sensPresS3,
    output logic [3:0] sensPresTubSR,
    output logic [3:0] sensPresTubSS,
    output logic [3:0] sensPresRea,
    output logic [6:0] falhaSensor,
    output logic       varreduraCompleta
);

    localparam logic [2:0] LP_PERSIST    = 3'(PERSIST);
    localparam logic [7:0] LP_ESPERA_MAX = 8'(TIMEOUT - 1);
    localparam logic [2:0] LP_ULT_CANAL  = 3'd6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ESPERA   = 2'd1,
        ATUALIZA = 2'd2
    } estado_t;

    estado_t    r_estado;
    logic [2:0] r_canal;
    logic [7:0] r_espera;
    logic [3:0] r_amostra;
    logic       r_valido;
    logic       r_req;
    logic       r_varre;
    logic [6:0] r_falha;
    logic [3:0] r_cand  [0:6];
    logic [2:0] r_cnt   [0:6];
    logic [3:0] r_saida [0:6];

    logic       w_igual;
    logic [2:0] w_cnt_atual;
    logic [2:0] w_cnt_novo;
    logic       w_sai_espera;

    always_comb begin
        w_igual      = (r_amostra == r_cand[r_canal]);
        w_cnt_atual  = r_cnt[r_canal];
        w_cnt_novo   = 3'd1;
        if (w_igual) begin
            w_cnt_novo = (w_cnt_atual >= LP_PERSIST) ? LP_PERSIST : w_cnt_atual + 3'd1;
        end
        // A sample on the last allowed cycle wins over the timeout.
        w_sai_espera = validoADC || (r_espera == LP_ESPERA_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado  <= IDLE;
            r_canal   <= 3'd0;
            r_espera  <= 8'd0;
            r_amostra <= 4'd0;
            r_valido  <= 1'b0;
            r_req     <= 1'b0;
            r_varre   <= 1'b0;
            r_falha   <= 7'd0;
            for (int i = 0; i < 7; i++) begin
                r_cand[i]  <= 4'd0;
                r_cnt[i]   <= 3'd0;
                r_saida[i] <= 4'd0;
            end
        end else begin
            r_varre <= 1'b0;
            case (r_estado)
                IDLE: begin
                    if (habilita) begin
                        r_estado <= ESPERA;
                        r_req    <= 1'b1;
                        r_espera <= 8'd0;
                    end
                end
                ESPERA: begin
                    if (w_sai_espera) begin
                        r_amostra <= dadoADC;
                        r_valido  <= validoADC;
                        r_req     <= 1'b0;
                        r_varre   <= (r_canal == LP_ULT_CANAL);
                        r_estado  <= ATUALIZA;
                    end else begin
                        r_espera <= r_espera + 8'd1;
                    end
                end
                ATUALIZA: begin
                    if (r_valido) begin
                        r_cnt[r_canal]   <= w_cnt_novo;
                        r_falha[r_canal] <= 1'b0;
                        if (!w_igual) begin
                            r_cand[r_canal] <= r_amostra;
                        end
                        // Candidate equals the sample on both paths, so the sample is what gets published.
                        if (w_cnt_novo == LP_PERSIST) begin
                            r_saida[r_canal] <= r_amostra;
                        end
                    end else begin
                        r_falha[r_canal] <= 1'b1;
                        r_cnt[r_canal]   <= 3'd0;
                    end
                    r_canal  <= (r_canal == LP_ULT_CANAL) ? 3'd0 : r_canal + 3'd1;
                    r_espera <= 8'd0;
                    if (habilita) begin
                        r_estado <= ESPERA;
                        r_req    <= 1'b1;
                    end else begin
                        r_estado <= IDLE;
                    end
                end
                default: begin
                    r_estado <= IDLE;
                    r_req    <= 1'b0;
                end
            endcase
        end
    end

    assign reqAmostra        = r_req;
    assign canalSel          = r_canal;
    assign falhaSensor       = r_falha;
    assign varreduraCompleta = r_varre;
    assign sensPresSC        = r_saida[0];
    assign sensPresS1        = r_saida[1];
    assign sensPresS2        = r_saida[2];
    assign sensPresS3        = r_saida[3];
    assign sensPresTubSR     = r_saida[4];
    assign sensPresTubSS     = r_saida[5];
    assign sensPresRea       = r_saida[6];

endmodule

// File: tb/tb_aquisicao_pressao.sv
// Directed bench for aquisicao_pressao: a scripted converter answers each request and outputs are checked between scans.
module tb_aquisicao_pressao;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       habilita = 1'b0;
    logic       reqAmostra;
    logic [2:0] canalSel;
    logic [3:0] dadoADC = 4'd0;
    logic       validoADC = 1'b0;
    logic [3:0] sensPresSC, sensPresS1, sensPresS2, sensPresS3;
    logic [3:0] sensPresTubSR, sensPresTubSS, sensPresRea;
    logic [6:0] falhaSensor;
    logic       varreduraCompleta;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ult_pulso = -1;
    bit chk_periodo = 1'b0;

    logic [27:0] saidas;
    assign saidas = {sensPresRea, sensPresTubSS, sensPresTubSR, sensPresS3,
                     sensPresS2, sensPresS1, sensPresSC};

    aquisicao_pressao #(.PERSIST(3), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .habilita(habilita),
        .reqAmostra(reqAmostra), .canalSel(canalSel),
        .dadoADC(dadoADC), .validoADC(validoADC),
        .sensPresSC(sensPresSC), .sensPresS1(sensPresS1), .sensPresS2(sensPresS2),
        .sensPresS3(sensPresS3), .sensPresTubSR(sensPresTubSR),
        .sensPresTubSS(sensPresTubSS), .sensPresRea(sensPresRea),
        .falhaSensor(falhaSensor), .varreduraCompleta(varreduraCompleta)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serves one channel; returns at the negedge inside ATUALIZA. atraso < 0 means never answer.
    task automatic atende(input logic [2:0] ch, input logic [3:0] d, input int atraso);
        int n;
        n = 0;
        while (reqAmostra !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("req_wait", 32'(n < 64), 32'd1);
        chk("canal", 32'(canalSel), 32'(ch));
        if (atraso < 0) begin
            n = 0;
            while (reqAmostra === 1'b1 && n < 300) begin
                chk("canal_estavel", 32'(canalSel), 32'(ch));
                @(negedge clk);
                n++;
            end
            chk("req_ciclos", 32'(n), 32'd15);
        end else begin
            repeat (atraso) @(negedge clk);
            chk("req_antes_valid", 32'(reqAmostra), 32'd1);
            validoADC = 1'b1;
            dadoADC   = d;
            @(negedge clk);
            validoADC = 1'b0;
        end
        chk("req_atualiza", 32'(reqAmostra), 32'd0);
        chk("varredura", 32'(varreduraCompleta), 32'(ch == 3'd6));
        if (ch == 3'd6) begin
            if (chk_periodo && ult_pulso >= 0) chk("periodo", 32'(cyc - ult_pulso), 32'd14);
            ult_pulso = cyc;
        end
    endtask

    // One full scan; d[c] is channel c's sample. Returns at the first negedge after the scan.
    task automatic varre(input logic [6:0][3:0] d, input logic [2:0] ch_esp,
                         input int at_esp, input bit glitch);
        for (int c = 0; c < 7; c++) begin
            atende(3'(c), d[c], (3'(c) == ch_esp) ? at_esp : 0);
            if (glitch) begin
                validoADC = 1'b1;
                dadoADC   = 4'h9;
            end
            @(negedge clk);
            validoADC = 1'b0;
        end
    endtask

    task automatic chk_estado(input string tag, input logic [27:0] exp_s, input logic [6:0] exp_f);
        chk({tag, "_saidas"}, 32'(saidas), 32'(exp_s));
        chk({tag, "_falha"}, 32'(falhaSensor), 32'(exp_f));
        chk({tag, "_pulso"}, 32'(varreduraCompleta), 32'd0);
    endtask

    initial begin
        // Reset state, then idle with habilita low
        repeat (2) @(negedge clk);
        chk_estado("reset", 28'h0, 7'h0);
        chk("reset_req", 32'(reqAmostra), 32'd0);
        chk("reset_canal", 32'(canalSel), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_req", 32'(reqAmostra), 32'd0);

        // Three scans of constant 5
        habilita = 1'b1;
        chk_periodo = 1'b1;
        varre(28'h5555555, 3'd7, 0, 1'b0);
        chk_estado("scan1", 28'h0, 7'h0);
        varre(28'h5555555, 3'd7, 0, 1'b0);
        chk_estado("scan2", 28'h0, 7'h0);
        varre(28'h5555555, 3'd7, 0, 1'b0);
        chk_estado("scan3", 28'h5555555, 7'h0);
        chk_periodo = 1'b0;

        // Reset during ESPERA of channel 0
        chk("pre_reset_req", 32'(reqAmostra), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_saidas", 32'(saidas), 32'd0);
        chk("rst_req", 32'(reqAmostra), 32'd0);
        chk("rst_canal", 32'(canalSel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Channel 6 sees -1,-1,-2,-2,-2; counters must start cleared
        varre(28'hF555555, 3'd7, 0, 1'b0);
        chk_estado("rea1", 28'h0, 7'h0);
        varre(28'hF555555, 3'd7, 0, 1'b0);
        chk_estado("rea2", 28'h0, 7'h0);
        varre(28'hE555555, 3'd7, 0, 1'b0);
        chk_estado("rea3", 28'h0555555, 7'h0);
        varre(28'hE555555, 3'd7, 0, 1'b0);
        chk_estado("rea4", 28'h0555555, 7'h0);
        varre(28'hE555555, 3'd7, 0, 1'b0);
        chk_estado("rea5", 28'hE555555, 7'h0);

        // Channel 4 never answers, then recovers with 3
        varre(28'hE555555, 3'd4, -1, 1'b0);
        chk_estado("timeout", 28'hE555555, 7'h10);
        varre(28'hE535555, 3'd7, 0, 1'b0);
        chk_estado("recup1", 28'hE555555, 7'h00);
        varre(28'hE535555, 3'd7, 0, 1'b0);
        chk_estado("recup2", 28'hE555555, 7'h00);
        varre(28'hE535555, 3'd7, 0, 1'b0);
        chk_estado("recup3", 28'hE535555, 7'h00);

        // Channel 3 answers 7 on the 15th ESPERA cycle; strobes during ATUALIZA are ignored
        varre(28'hE537555, 3'd3, 14, 1'b1);
        chk_estado("tardio1", 28'hE535555, 7'h00);
        varre(28'hE537555, 3'd3, 14, 1'b1);
        chk_estado("tardio2", 28'hE535555, 7'h00);
        varre(28'hE537555, 3'd3, 14, 1'b1);
        chk_estado("tardio3", 28'hE537555, 7'h00);

        // habilita dropped during ESPERA of channel 2
        atende(3'd0, 4'h5, 0);
        @(negedge clk);
        atende(3'd1, 4'h5, 0);
        @(negedge clk);
        habilita = 1'b0;
        atende(3'd2, 4'h5, 0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            validoADC = 1'b1;
            dadoADC   = 4'h9;
            chk("idle_req_baixo", 32'(reqAmostra), 32'd0);
            chk("idle_canal", 32'(canalSel), 32'd3);
            @(negedge clk);
        end
        validoADC = 1'b0;
        habilita = 1'b1;
        atende(3'd3, 4'h7, 0);
        @(negedge clk);
        atende(3'd4, 4'h3, 0);
        @(negedge clk);
        atende(3'd5, 4'h5, 0);
        @(negedge clk);
        atende(3'd6, 4'hE, 0);
        @(negedge clk);
        chk_estado("retoma", 28'hE537555, 7'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
